// File: rtl/iso_proj_pkg.sv
// Shared types and defaults for the isometric projection pipeline.
package iso_proj_pkg;

  typedef enum logic [1:0] {
    MODE_ISO        = 2'd0,
    MODE_TOP        = 2'd1,
    MODE_FRONT      = 2'd2,
    MODE_ISO_MIRROR = 2'd3
  } mode_t;

  localparam logic [1:0] CFG_K    = 2'd0;
  localparam logic [1:0] CFG_XOFF = 2'd1;
  localparam logic [1:0] CFG_YOFF = 2'd2;

  localparam int K_DEFAULT = 362;  // ~0.3535 in Q.10
  localparam int FRAC      = 10;

endpackage

// File: rtl/iso_sat.sv
// Signed saturator: clamps an IW-bit value into OW bits and flags clamping.
module iso_sat #(
  parameter int IW = 12,
  parameter int OW = 10
) (
  input  logic signed [IW-1:0] a,
  output logic signed [OW-1:0] y,
  output logic                 sat
);

  localparam logic signed [IW-1:0] MAXV = IW'((1 << (OW - 1)) - 1);
  localparam logic signed [IW-1:0] MINV = IW'(-(1 << (OW - 1)));

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    sat = 1'b1;
    y   = MAXV[OW-1:0];
    if (a > MAXV) begin
      y = MAXV[OW-1:0];
    end else if (a < MINV) begin
      y = MINV[OW-1:0];
    end else begin
      sat = 1'b0;
      y   = a[OW-1:0];
    end
  end

endmodule

// File: rtl/iso_proj_pipe.sv
// Three-stage 3D-to-2D vertex projector with valid/ready flow control,
// programmable depth coefficient and screen offsets.
module iso_proj_pipe
  import iso_proj_pkg::*;
#(
  parameter int W         = 10,
  parameter int KW        = 11,
  parameter int FRAC      = iso_proj_pkg::FRAC,
  parameter int K_DEFAULT = iso_proj_pkg::K_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     x_i,
  input  logic [W-1:0]     y_i,
  input  logic [W-1:0]     z_i,
  input  logic [1:0]       mode_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [15:0]      cfg_wdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     x_o,
  output logic [W-1:0]     y_o,
  output logic             clip_o,
  output logic [CNT_W-1:0] vtx_cnt_o
);

  logic signed [KW-1:0] k_q;
  logic signed [W-1:0]  xoff_q, yoff_q;

  logic                 v1, v2;
  logic signed [W-1:0]  x1, y1, z1, xo1, yo1;
  logic signed [KW-1:0] k1;
  mode_t                m1;
  logic signed [W+1:0]  xs2, ys2;

  logic signed [W+KW-1:0] p;
  logic signed [W:0]      t;
  logic signed [W+1:0]    xe, ye, ze, te, xoe, yoe, xs_n, ys_n;
  logic signed [W-1:0]    xsat, ysat;
  logic                   xclip, yclip;

  logic stall;
  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;

  // Depth term: y*K then arithmetic shift (floors toward -inf).
  assign p   = (W+KW)'(y1) * (W+KW)'(k1);
  assign t   = (W+1)'(p >>> FRAC);
  assign xe  = (W+2)'(x1);
  assign ye  = (W+2)'(y1);
  assign ze  = (W+2)'(z1);
  assign te  = (W+2)'(t);
  assign xoe = (W+2)'(xo1);
  assign yoe = (W+2)'(yo1);

  always_comb begin
    xs_n = xe + xoe;
    ys_n = ze + yoe;
    case (m1)
      MODE_ISO: begin
        xs_n = xe + te + xoe;
        ys_n = ze - te + yoe;
      end
      MODE_ISO_MIRROR: begin
        xs_n = xe - te + xoe;
        ys_n = ze - te + yoe;
      end
      MODE_TOP: begin
        xs_n = xe + xoe;
        ys_n = ye + yoe;
      end
      default: begin
        xs_n = xe + xoe;
        ys_n = ze + yoe;
      end
    endcase
  end

  iso_sat #(.IW(W + 2), .OW(W)) u_sat_x (.a(xs2), .y(xsat), .sat(xclip));
  iso_sat #(.IW(W + 2), .OW(W)) u_sat_y (.a(ys2), .y(ysat), .sat(yclip));

  always_ff @(posedge clk_i) begin
    // NOTE: datapath registers are reset too, so the outputs read 0 after reset.
    if (!rst_ni) begin
      k_q         <= KW'(K_DEFAULT);
      xoff_q      <= '0;
      yoff_q      <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      x1          <= '0;
      y1          <= '0;
      z1          <= '0;
      xo1         <= '0;
      yo1         <= '0;
      k1          <= '0;
      m1          <= MODE_ISO;
      xs2         <= '0;
      ys2         <= '0;
      out_valid_o <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      clip_o      <= 1'b0;
      vtx_cnt_o   <= '0;
    end else begin
      if (cfg_we_i) begin
        case (cfg_addr_i)
          CFG_K:    k_q    <= cfg_wdata_i[KW-1:0];
          CFG_XOFF: xoff_q <= cfg_wdata_i[W-1:0];
          CFG_YOFF: yoff_q <= cfg_wdata_i[W-1:0];
          default:  ;
        endcase
      end
      // The whole pipe freezes on stall; config snapshots travel with the vertex.
      if (!stall) begin
        v1  <= in_valid_i;
        x1  <= x_i;
        y1  <= y_i;
        z1  <= z_i;
        m1  <= mode_t'(mode_i);
        k1  <= k_q;
        xo1 <= xoff_q;
        yo1 <= yoff_q;
        v2  <= v1;
        xs2 <= xs_n;
        ys2 <= ys_n;
        out_valid_o <= v2;
        if (v2) begin
          x_o    <= xsat;
          y_o    <= ysat;
          clip_o <= xclip | yclip;
        end
      end
      if (out_valid_o && out_ready_i) vtx_cnt_o <= vtx_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_iso_proj_pipe.sv
// Directed bench for iso_proj_pipe: reference model with a per-cycle compare
// process plus hand-computed literal checks.
module tb_iso_proj_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  x_in = '0, y_in = '0, z_in = '0;
  logic [1:0]  mode = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  x_out, y_out;
  logic        clip;
  logic [15:0] vtx_cnt;

  int total = 0;
  int bad = 0;

  iso_proj_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x_i(x_in), .y_i(y_in), .z_i(z_in), .mode_i(mode),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .x_o(x_out), .y_o(y_out), .clip_o(clip), .vtx_cnt_o(vtx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input int act, input int exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int x; int y; int c; } exp_t;
  exp_t exp_q[$];
  int   mk = 362, mxo = 0, myo = 0;
  int   exp_cnt = 0;
  bit   prev_stall = 0;
  int   prev_x, prev_y, prev_c;

  function automatic int floor_div1024(input int a);
    int q;
    q = a / 1024;
    if ((a % 1024 != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int v, output bit s);
    s = 1'b1;
    if (v > 511) return 511;
    if (v < -512) return -512;
    s = 1'b0;
    return v;
  endfunction

  function automatic exp_t project(input int x, input int y, input int z, input int m);
    exp_t e;
    int t, xx, yy;
    bit sx, sy;
    t = floor_div1024(y * mk);
    case (m)
      0:       begin xx = x + t + mxo; yy = z - t + myo; end
      3:       begin xx = x - t + mxo; yy = z - t + myo; end
      1:       begin xx = x + mxo;     yy = y + myo;     end
      default: begin xx = x + mxo;     yy = z + myo;     end
    endcase
    e.x = clamp(xx, sx);
    e.y = clamp(yy, sy);
    e.c = int'(sx | sy);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check(int'(in_ready), int'(!(out_valid && !out_ready)), "in_ready_rule");
      check(int'(vtx_cnt), exp_cnt % 65536, "vtx_cnt");
      if (prev_stall) begin
        check(int'(out_valid), 1, "stall_valid_hold");
        check(int'($signed(x_out)), prev_x, "stall_x_hold");
        check(int'($signed(y_out)), prev_y, "stall_y_hold");
        check(int'(clip), prev_c, "stall_clip_hold");
      end
      if (out_valid && out_ready) begin
        check(int'(exp_q.size() > 0), 1, "pending_expected");
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(int'($signed(x_out)), e.x, "model_x");
          check(int'($signed(y_out)), e.y, "model_y");
          check(int'(clip), e.c, "model_clip");
        end
        exp_cnt++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(project(int'($signed(x_in)), int'($signed(y_in)),
                                int'($signed(z_in)), int'(mode)));
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: mk  = int'($signed(cfg_wdata[10:0]));
          2'd1: mxo = int'($signed(cfg_wdata[9:0]));
          2'd2: myo = int'($signed(cfg_wdata[9:0]));
          default: ;
        endcase
      end
      prev_stall = out_valid && !out_ready;
      prev_x = int'($signed(x_out));
      prev_y = int'($signed(y_out));
      prev_c = int'(clip);
    end else begin
      exp_q.delete();
      mk = 362; mxo = 0; myo = 0;
      exp_cnt = 0;
      prev_stall = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_one(input int x, input int y, input int z, input int m,
                         input int ex, input int ey, input int ec, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1; x_in = 10'(x); y_in = 10'(y); z_in = 10'(z); mode = 2'(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check(int'(out_valid), 1, {name, "_valid"});
    check(int'($signed(x_out)), ex, {name, "_x"});
    check(int'($signed(y_out)), ey, {name, "_y"});
    check(int'(clip), ec, {name, "_clip"});
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  typedef struct { int x; int y; int z; int m; } vin_t;
  vin_t stream[6];

  initial begin
    int idx, delivered, c;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check(int'(out_valid), 0, "rst_out_valid");
    check(int'(x_out), 0, "rst_x");
    check(int'(y_out), 0, "rst_y");
    check(int'(clip), 0, "rst_clip");
    check(int'(vtx_cnt), 0, "rst_cnt");
    check(int'(in_ready), 1, "rst_in_ready");

    run_one(100, 64, 50, 0, 122, 28, 0, "iso_basic");
    run_one(100, -64, 50, 0, 77, 73, 0, "iso_negdepth");
    run_one(511, 511, 0, 0, 511, -180, 1, "iso_sat");
    run_one(-512, 511, 0, 3, -512, -180, 1, "mirror_sat");
    run_one(-7, 33, -99, 2, -7, -99, 0, "front");

    // Config write in the same cycle as vertex A; B follows one cycle later.
    @(posedge clk); #1;
    in_valid = 1'b1; x_in = 10'd5; y_in = 10'd7; z_in = 10'd0; mode = 2'd1;
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd10;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check(int'($signed(x_out)), 5, "cfg_old_x");
    check(int'($signed(y_out)), 7, "cfg_old_y");
    @(posedge clk); #1;
    check(int'($signed(x_out)), 15, "cfg_new_x");
    check(int'($signed(y_out)), 7, "cfg_new_y");
    cfg_write(2'd1, 16'd0);
    cfg_write(2'd3, 16'd77);
    cfg_write(2'd0, 16'hFE96);  // K = -362
    run_one(100, 64, 50, 0, 77, 73, 0, "negk");

    // Backpressure stream with a fresh counter and a y offset.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cfg_write(2'd2, 16'hFFEC);  // y_off = -20
    stream[0] = '{10, 20, 30, 0};
    stream[1] = '{-40, 100, 5, 3};
    stream[2] = '{300, -200, 0, 1};
    stream[3] = '{-100, 0, 500, 2};
    stream[4] = '{500, 400, 200, 0};
    stream[5] = '{-300, -300, -300, 3};
    idx = 0;
    delivered = 0;
    c = 0;
    while (c < 400 && delivered < 6) begin
      @(posedge clk); #1;
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      if (idx < 6) begin
        in_valid = 1'b1;
        x_in = 10'(stream[idx].x); y_in = 10'(stream[idx].y);
        z_in = 10'(stream[idx].z); mode = 2'(stream[idx].m);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) delivered++;
      c++;
    end
    check(delivered, 6, "bp_delivered");
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check(int'(vtx_cnt), 6, "bp_cnt");
    check(exp_q.size(), 0, "bp_drained");

    // Reset with two vertices in flight and K changed.
    cfg_write(2'd0, 16'd512);
    @(posedge clk); #1;
    in_valid = 1'b1; x_in = 10'd1; y_in = 10'd2; z_in = 10'd3; mode = 2'd0;
    @(posedge clk); #1;
    x_in = 10'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check(int'(out_valid), 0, "midrst_valid");
    check(int'(vtx_cnt), 0, "midrst_cnt");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check(int'(out_valid), 0, "midrst_no_stale");
    end
    run_one(100, 64, 50, 0, 122, 28, 0, "midrst_k_default");
    @(posedge clk); #1;
    check(exp_q.size(), 0, "final_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
